// File: rtl/freelist_pkg.sv
// Shared types and helpers for the physical register free list.
// DECODE_WIDTH / COMMIT_WIDTH fall back to 4 when the build does not define them.
// PREG_W tracks DEF_PHY_REG_NUM; change both together when resizing the register file.
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

package freelist_pkg;

    localparam int unsigned DEF_PHY_REG_NUM = 64;
    localparam int unsigned PREG_W          = $clog2(DEF_PHY_REG_NUM);

    typedef logic [PREG_W-1:0] preg_t;
    // MSB is the wrap bit so full and empty are distinguishable.
    typedef logic [PREG_W:0]   ptr_t;

    localparam preg_t RESERVED_PREG = '0;

    // Number of entries between head and tail, modulo the doubled pointer range.
    function automatic ptr_t ptr_count(input ptr_t tail, input ptr_t head);
        return tail - head;
    endfunction

endpackage

// File: rtl/free_list_slot_offset.sv
// Prefix popcount: slot i gets the number of set mask bits below it, plus a total.
module free_list_slot_offset #(
    parameter int unsigned  WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]            mask_i,
    output logic [WIDTH-1:0][CNT_W-1:0] offset_o,
    output logic [CNT_W-1:0]            total_o
);

    logic [CNT_W-1:0] acc;

    // Running sum across slots in ascending order.
    always_comb begin
        acc      = '0;
        offset_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            offset_o[i] = acc;
            acc         = acc + CNT_W'(mask_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/free_list.sv
// Free physical register list: allocates destinations to rename, reclaims previous
// mappings at commit, and rolls speculative allocation back to the committed head on flush.
// Optional build macro FREELIST_CHECK_EN adds an in-list bitmap and a sticky err_o.
module free_list
    import freelist_pkg::*;
#(
    parameter int unsigned PHY_REG_NUM  = DEF_PHY_REG_NUM,
    parameter int unsigned DECODE_WIDTH = `DECODE_WIDTH,
    parameter int unsigned COMMIT_WIDTH = `COMMIT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 alloc_valid_i,
    input  logic [DECODE_WIDTH-1:0]              alloc_req_i,
    output logic                                 alloc_ready_o,
    output logic [DECODE_WIDTH-1:0][PREG_W-1:0]  preg_o,
    input  logic [COMMIT_WIDTH-1:0]              commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0]              commit_dest_valid_i,
    input  logic [COMMIT_WIDTH-1:0][PREG_W-1:0]  commit_pdest_i,
    input  logic [COMMIT_WIDTH-1:0][PREG_W-1:0]  commit_ppdst_i,
    input  logic                                 restore_i,
    output logic [PHY_REG_NUM-1:0]               arch_valid_o,
    output logic [PREG_W:0]                      free_cnt_o,
    output logic                                 err_o
);

    localparam int unsigned ALLOC_CW  = $clog2(DECODE_WIDTH + 1);
    localparam int unsigned COMMIT_CW = $clog2(COMMIT_WIDTH + 1);

    preg_t                   ring_q [PHY_REG_NUM];
    ptr_t                    spec_head_q, spec_head_d;
    ptr_t                    arch_head_q, arch_head_d;
    ptr_t                    tail_q, tail_d;
    logic [PHY_REG_NUM-1:0]  arch_valid_q, arch_valid_d;

    ptr_t                                   free_cnt;
    logic                                   alloc_fire;
    logic [DECODE_WIDTH-1:0][ALLOC_CW-1:0]  alloc_off;
    logic [ALLOC_CW-1:0]                    alloc_total;
    ptr_t                                   alloc_ptr [DECODE_WIDTH];

    logic [COMMIT_WIDTH-1:0]                rec_mask;
    logic [COMMIT_WIDTH-1:0]                push_mask;
    logic [COMMIT_WIDTH-1:0][COMMIT_CW-1:0] push_off;
    logic [COMMIT_CW-1:0]                   push_total;
    ptr_t                                   push_ptr [COMMIT_WIDTH];
    ptr_t                                   rec_cnt;

    free_list_slot_offset #(
        .WIDTH    (DECODE_WIDTH)
    ) u_alloc_offset (
        .mask_i   (alloc_req_i),
        .offset_o (alloc_off),
        .total_o  (alloc_total)
    );

    free_list_slot_offset #(
        .WIDTH    (COMMIT_WIDTH)
    ) u_push_offset (
        .mask_i   (push_mask),
        .offset_o (push_off),
        .total_o  (push_total)
    );

    assign free_cnt      = ptr_count(tail_q, spec_head_q);
    assign free_cnt_o    = free_cnt;
    assign arch_valid_o  = arch_valid_q;
    // Readiness depends only on registered state, never on this cycle's pushes.
    assign alloc_ready_o = !restore_i && (free_cnt >= ptr_t'(alloc_total));
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;

    // Read ring entries for requesting slots; non-requesting slots show 0.
    always_comb begin
        preg_o = '0;
        for (int i = 0; i < int'(DECODE_WIDTH); i++) begin
            alloc_ptr[i] = spec_head_q + ptr_t'(alloc_off[i]);
            if (alloc_req_i[i]) begin
                preg_o[i] = ring_q[alloc_ptr[i][PREG_W-1:0]];
            end
        end
    end

    // Reclaim masks: every dest-writing commit advances arch_head, only nonzero ppdst is pushed.
    always_comb begin
        rec_mask  = commit_valid_i & commit_dest_valid_i;
        push_mask = '0;
        rec_cnt   = '0;
        for (int c = 0; c < int'(COMMIT_WIDTH); c++) begin
            push_mask[c] = rec_mask[c] && (commit_ppdst_i[c] != RESERVED_PREG);
            rec_cnt      = rec_cnt + ptr_t'(rec_mask[c]);
            push_ptr[c]  = tail_q + ptr_t'(push_off[c]);
        end
    end

    // Next pointer values; restore rewinds to the committed head including this cycle's commits.
    always_comb begin
        arch_head_d = arch_head_q + rec_cnt;
        tail_d      = tail_q + ptr_t'(push_total);
        spec_head_d = spec_head_q;
        if (restore_i) begin
            spec_head_d = arch_head_d;
        end else if (alloc_fire) begin
            spec_head_d = spec_head_q + ptr_t'(alloc_total);
        end
    end

    // Committed-mapping bitmap; slot order makes a later clear beat an earlier set.
    always_comb begin
        arch_valid_d = arch_valid_q;
        for (int c = 0; c < int'(COMMIT_WIDTH); c++) begin
            if (rec_mask[c]) begin
                arch_valid_d[commit_pdest_i[c]] = 1'b1;
                if (commit_ppdst_i[c] != RESERVED_PREG) begin
                    arch_valid_d[commit_ppdst_i[c]] = 1'b0;
                end
            end
        end
    end

    // Pointer and bitmap state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_head_q  <= '0;
            arch_head_q  <= '0;
            tail_q       <= ptr_t'(PHY_REG_NUM - 1);
            arch_valid_q <= '0;
        end else begin
            spec_head_q  <= spec_head_d;
            arch_head_q  <= arch_head_d;
            tail_q       <= tail_d;
            arch_valid_q <= arch_valid_d;
        end
    end

    // Ring storage: preload 1..N-1, then write reclaimed registers at the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(PHY_REG_NUM); k++) begin
                ring_q[k] <= preg_t'((k + 1) % int'(PHY_REG_NUM));
            end
        end else begin
            for (int c = 0; c < int'(COMMIT_WIDTH); c++) begin
                if (push_mask[c]) begin
                    ring_q[push_ptr[c][PREG_W-1:0]] <= commit_ppdst_i[c];
                end
            end
        end
    end

`ifdef FREELIST_CHECK_EN
    logic [PHY_REG_NUM-1:0] in_list_q, in_list_d;
    logic                   err_q, err_d;
    ptr_t                   free_cnt_d;
    ptr_t                   restore_span;
    preg_t                  rel_idx;

    assign free_cnt_d = ptr_count(tail_d, spec_head_d);
    assign err_o      = err_q;

    // Track list membership; allocation clears, restore re-lists the rewound window, push sets.
    always_comb begin
        in_list_d    = in_list_q;
        err_d        = err_q;
        restore_span = '0;
        rel_idx      = '0;
        if (alloc_fire) begin
            for (int i = 0; i < int'(DECODE_WIDTH); i++) begin
                if (alloc_req_i[i]) begin
                    if (!in_list_d[preg_o[i]]) begin
                        err_d = 1'b1;
                    end
                    in_list_d[preg_o[i]] = 1'b0;
                end
            end
        end
        if (restore_i) begin
            restore_span = spec_head_q - arch_head_d;
            for (int k = 0; k < int'(PHY_REG_NUM); k++) begin
                rel_idx = preg_t'(k) - arch_head_d[PREG_W-1:0];
                if ({1'b0, rel_idx} < restore_span) begin
                    in_list_d[ring_q[k]] = 1'b1;
                end
            end
        end
        for (int c = 0; c < int'(COMMIT_WIDTH); c++) begin
            if (push_mask[c]) begin
                if (in_list_d[commit_ppdst_i[c]]) begin
                    err_d = 1'b1;
                end
                in_list_d[commit_ppdst_i[c]] = 1'b1;
            end
        end
        if (free_cnt_d > ptr_t'(PHY_REG_NUM - 1)) begin
            err_d = 1'b1;
        end
    end

    // Membership bitmap and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_list_q <= {{(PHY_REG_NUM - 1){1'b1}}, 1'b0};
            err_q     <= 1'b0;
        end else begin
            in_list_q <= in_list_d;
            err_q     <= err_d;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: a queue-based reference model of free,
// in-flight and architecturally held registers, with a scoreboard for allocations.
module tb_free_list;

    logic             clk;
    logic             rst;
    logic             alloc_valid_i;
    logic [3:0]       alloc_req_i;
    logic             alloc_ready_o;
    logic [3:0][5:0]  preg_o;
    logic [3:0]       commit_valid_i;
    logic [3:0]       commit_dest_valid_i;
    logic [3:0][5:0]  commit_pdest_i;
    logic [3:0][5:0]  commit_ppdst_i;
    logic             restore_i;
    logic [63:0]      arch_valid_o;
    logic [6:0]       free_cnt_o;
    logic             err_o;

    free_list u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .alloc_valid_i       (alloc_valid_i),
        .alloc_req_i         (alloc_req_i),
        .alloc_ready_o       (alloc_ready_o),
        .preg_o              (preg_o),
        .commit_valid_i      (commit_valid_i),
        .commit_dest_valid_i (commit_dest_valid_i),
        .commit_pdest_i      (commit_pdest_i),
        .commit_ppdst_i      (commit_ppdst_i),
        .restore_i           (restore_i),
        .arch_valid_o        (arch_valid_o),
        .free_cnt_o          (free_cnt_o),
        .err_o               (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int          free_q [$];
    int          infl_q [$];
    int          held_q [$];
    int          exp_q  [$];
    logic [63:0] av_m;
    logic        err_m;

    // Commit stimulus for the next cycle() call.
    logic [3:0]      c_v, c_dv;
    logic [3:0][5:0] c_pd, c_pp;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        infl_q.delete();
        held_q.delete();
        exp_q.delete();
        for (int k = 1; k < 64; k++) free_q.push_back(k);
        av_m  = '0;
        err_m = 1'b0;
    endtask

    task automatic clear_commit();
        c_v  = '0;
        c_dv = '0;
        c_pd = '0;
        c_pp = '0;
    endtask

    // One clock: drive, check combinational outputs, advance model, check registered outputs.
    task automatic cycle(input logic av, input logic [3:0] req, input logic rs);
        int   n;
        int   k;
        int   e;
        logic rdy_m;
        alloc_valid_i       = av;
        alloc_req_i         = req;
        restore_i           = rs;
        commit_valid_i      = c_v;
        commit_dest_valid_i = c_dv;
        commit_pdest_i      = c_pd;
        commit_ppdst_i      = c_pp;
        n     = $countones(req);
        rdy_m = !rs && (free_q.size() >= n);
        #1;
        check_val("alloc_ready", 64'(alloc_ready_o), 64'(rdy_m));
        if (rdy_m) begin
            k = 0;
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    exp_q.push_back(free_q[k]);
                    k++;
                end else begin
                    exp_q.push_back(0);
                end
            end
            for (int i = 0; i < 4; i++) begin
                e = exp_q.pop_front();
                check_val($sformatf("preg[%0d]", i), 64'(preg_o[i]), 64'(e));
            end
            if (av) begin
                for (int j = 0; j < n; j++) infl_q.push_back(free_q.pop_front());
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (c_v[c] && c_dv[c]) begin
                if (infl_q.size() > 0) void'(infl_q.pop_front());
                av_m[c_pd[c]] = 1'b1;
                if (c_pp[c] != 6'd0) begin
                    av_m[c_pp[c]] = 1'b0;
                    free_q.push_back(int'(c_pp[c]));
                end
            end
        end
        if (rs) begin
            free_q = {infl_q, free_q};
            infl_q.delete();
        end
        @(posedge clk);
        #1;
        check_val("free_cnt", 64'(free_cnt_o), 64'(free_q.size()));
        check_val("arch_valid", arch_valid_o, av_m);
        check_val("err", 64'(err_o), 64'(err_m));
        clear_commit();
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        alloc_valid_i       = 1'b0;
        alloc_req_i         = '0;
        restore_i           = 1'b0;
        commit_valid_i      = '0;
        commit_dest_valid_i = '0;
        commit_pdest_i      = '0;
        commit_ppdst_i      = '0;
        clear_commit();
        model_reset();
        #2;
        check_val("rst_free_cnt", 64'(free_cnt_o), 64'd63);
        check_val("rst_arch_valid", arch_valid_o, 64'd0);
        check_val("rst_err", 64'(err_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("rst_ready", 64'(alloc_ready_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    int              used;
    int              idx;
    int              pds [$];
    logic            rs_r;

    initial begin
        rst = 1'b0;
        do_reset();

        // Reset allocation of a sparse group.
        alloc_valid_i = 1'b1;
        alloc_req_i   = 4'b1011;
        #1;
        check_val("t1_preg0", 64'(preg_o[0]), 64'd1);
        check_val("t1_preg1", 64'(preg_o[1]), 64'd2);
        check_val("t1_preg2", 64'(preg_o[2]), 64'd0);
        check_val("t1_preg3", 64'(preg_o[3]), 64'd3);
        cycle(1'b1, 4'b1011, 1'b0);
        check_val("t1_cnt", 64'(free_cnt_o), 64'd60);

        // Drain to two free, then the under-supply boundary.
        for (int i = 0; i < 14; i++) cycle(1'b1, 4'b1111, 1'b0);
        cycle(1'b1, 4'b0011, 1'b0);
        check_val("t2_cnt2", 64'(free_cnt_o), 64'd2);
        cycle(1'b1, 4'b0111, 1'b0);
        check_val("t2_blocked_cnt", 64'(free_cnt_o), 64'd2);
        cycle(1'b1, 4'b0011, 1'b0);
        check_val("t2_empty", 64'(free_cnt_o), 64'd0);
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b1, 4'b0001, 1'b0);

        // Reclaim with a zero ppdst in slot 1.
        c_v = 4'b0011; c_dv = 4'b0011;
        c_pd[0] = 6'd7; c_pp[0] = 6'd5;
        c_pd[1] = 6'd9; c_pp[1] = 6'd0;
        cycle(1'b0, 4'b0000, 1'b0);
        check_val("t3_cnt", 64'(free_cnt_o), 64'd1);
        check_val("t3_av", arch_valid_o & 64'h2A0, 64'h280);
        alloc_req_i = 4'b0001;
        #1;
        check_val("t3_tail_val", 64'(preg_o[0]), 64'd5);
        cycle(1'b1, 4'b0001, 1'b0);

        // Restore after partial commit.
        do_reset();
        cycle(1'b1, 4'b1111, 1'b0);
        cycle(1'b1, 4'b1111, 1'b0);
        c_v = 4'b0111; c_dv = 4'b0111;
        c_pd[0] = 6'd1; c_pd[1] = 6'd2; c_pd[2] = 6'd3;
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b1, 4'b1111, 1'b1);
        check_val("t4_cnt", 64'(free_cnt_o), 64'd60);
        alloc_valid_i = 1'b1;
        alloc_req_i   = 4'b0001;
        restore_i     = 1'b0;
        #1;
        check_val("t4_first", 64'(preg_o[0]), 64'd4);
        cycle(1'b1, 4'b0001, 1'b0);

        // Random traffic against the reference model, crossing many pointer wraps.
        do_reset();
        for (int t = 0; t < 200; t++) begin
            used = 0;
            clear_commit();
            pds.delete();
            for (int c = 0; c < 4; c++) begin
                c_v[c] = 1'($urandom % 2);
                if (c_v[c] && ($urandom % 4 != 0) && used < infl_q.size()) begin
                    c_dv[c] = 1'b1;
                    c_pd[c] = 6'(infl_q[used]);
                    used++;
                    if (held_q.size() > 0 && ($urandom % 3 != 0)) begin
                        idx     = $urandom_range(0, held_q.size() - 1);
                        c_pp[c] = 6'(held_q[idx]);
                        held_q.delete(idx);
                    end
                    pds.push_back(int'(c_pd[c]));
                end
            end
            rs_r = ($urandom % 20 == 0);
            cycle(1'($urandom % 4 != 0), 4'($urandom), rs_r);
            foreach (pds[i]) held_q.push_back(pds[i]);
        end

        // Mid-run reset must land in the reset state immediately.
        do_reset();

`ifdef FREELIST_CHECK_EN
        // Double reclaim of the same register sets the sticky error.
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1111, 1'b0);
        c_v = 4'b0001; c_dv = 4'b0001; c_pd[0] = 6'd1; c_pp[0] = 6'd12;
        cycle(1'b0, 4'b0000, 1'b0);
        c_v = 4'b0001; c_dv = 4'b0001; c_pd[0] = 6'd2; c_pp[0] = 6'd12;
        err_m = 1'b1;
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
